sm_color_classifier: RTL and testbench



---
 rtl/sm_color_classifier.sv | 162 ++++++++++++++++
 tb/tb_sm_color_classifier.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sm_color_classifier.sv
// TCS3200 colour classifier: windows each sweep against three reference signatures,
// debounces the class over consecutive sweeps, and flags a fault when sweeps stop arriving.
module sm_color_classifier #(
   parameter int W       = 21,
   parameter int TOL     = 200,
   parameter int CONFIRM = 4,
   parameter int TIMEOUT = 5000000,
   parameter logic [4*W-1:0] REF_RED   = {21'd1010, 21'd1370, 21'd1543, 21'd480},
   parameter logic [4*W-1:0] REF_GREEN = {21'd1510, 21'd1400, 21'd1390, 21'd500},
   parameter logic [4*W-1:0] REF_BLUE  = {21'd1800, 21'd970, 21'd1630, 21'd485}
) (
   input  logic         clk_50M,
   input  logic         reset,
   input  logic [W-1:0] red_cnt,
   input  logic [W-1:0] blue_cnt,
   input  logic [W-1:0] green_cnt,
   input  logic [W-1:0] clear_cnt,
   input  logic         cnt_valid,
   output logic [1:0]   color_code,
   output logic         red_led,
   output logic         green_led,
   output logic         blue_led,
   output logic         color_changed,
   output logic         sensor_fault
);

   localparam int WP = W + 1;
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam int RW = 4;
   localparam logic [W:0]    TOL_W   = WP'(TOL);
   localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT);
   localparam logic [TW-1:0] TMO_PRE = TW'(TIMEOUT - 1);
   localparam logic [RW-1:0] RUN_MAX = RW'(CONFIRM);

   // Window bounds are computed one bit wider so ref+TOL never wraps; ref-TOL floors at 0.
   function automatic logic in_window(input logic [W-1:0] cnt, input logic [W-1:0] ref_v);
      logic [W:0] lo;
      logic [W:0] hi;
      hi = {1'b0, ref_v} + TOL_W;
      lo = ({1'b0, ref_v} > TOL_W) ? ({1'b0, ref_v} - TOL_W) : '0;
      return ({1'b0, cnt} > lo) && ({1'b0, cnt} < hi);
   endfunction

   function automatic logic [3:0] sig_flags(input logic [W-1:0] r, input logic [W-1:0] b,
                                            input logic [W-1:0] g, input logic [W-1:0] c,
                                            input logic [4*W-1:0] sig);
      return {in_window(r, sig[4*W-1:3*W]), in_window(b, sig[3*W-1:2*W]),
              in_window(g, sig[2*W-1:W]),   in_window(c, sig[W-1:0])};
   endfunction

   logic [W-1:0]  s1_r, s1_b, s1_g, s1_c;
   logic          s1_v;
   logic [3:0]    s2_red_f, s2_green_f, s2_blue_f;
   logic          s2_zero, s2_v;
   logic [1:0]    cand;
   logic [RW-1:0] run;
   logic [TW-1:0] tmo_cnt;
   logic          tmo_hit;
   logic [1:0]    cls;
   logic [RW-1:0] run_nxt;

   // Stage 0: counts are sampled only on the strobe; there is no back-pressure.
   always_ff @(posedge clk_50M or posedge reset) begin
      if (reset) begin
         s1_v <= 1'b0;
         s1_r <= '0;
         s1_b <= '0;
         s1_g <= '0;
         s1_c <= '0;
      end else begin
         s1_v <= cnt_valid;
         if (cnt_valid) begin
            s1_r <= red_cnt;
            s1_b <= blue_cnt;
            s1_g <= green_cnt;
            s1_c <= clear_cnt;
         end
      end
   end

   always_ff @(posedge clk_50M or posedge reset) begin
      if (reset) begin
         s2_v       <= 1'b0;
         s2_red_f   <= '0;
         s2_green_f <= '0;
         s2_blue_f  <= '0;
         s2_zero    <= 1'b0;
      end else begin
         s2_v       <= s1_v;
         s2_red_f   <= sig_flags(s1_r, s1_b, s1_g, s1_c, REF_RED);
         s2_green_f <= sig_flags(s1_r, s1_b, s1_g, s1_c, REF_GREEN);
         s2_blue_f  <= sig_flags(s1_r, s1_b, s1_g, s1_c, REF_BLUE);
         s2_zero    <= (s1_r == '0) || (s1_b == '0) || (s1_g == '0) || (s1_c == '0);
      end
   end

   always_comb begin
      cls = 2'd0;
      if (!s2_zero) begin
         if (&s2_red_f)
            cls = 2'd1;
         else if (&s2_green_f)
            cls = 2'd2;
         else if (&s2_blue_f)
            cls = 2'd3;
      end
      if (cls == cand)
         run_nxt = (run == RUN_MAX) ? run : run + 1'b1;
      else
         run_nxt = RW'(1);
   end

   assign tmo_hit = !cnt_valid && (tmo_cnt == TMO_PRE);

   always_ff @(posedge clk_50M or posedge reset) begin
      if (reset)
         tmo_cnt <= '0;
      else if (cnt_valid)
         tmo_cnt <= '0;
      else if (tmo_cnt != TMO_MAX)
         tmo_cnt <= tmo_cnt + 1'b1;
   end

   // A timeout on the same edge as a stage-2 sample takes precedence over the debounce.
   always_ff @(posedge clk_50M or posedge reset) begin
      if (reset) begin
         cand          <= 2'd0;
         run           <= '0;
         color_code    <= 2'd0;
         red_led       <= 1'b0;
         green_led     <= 1'b0;
         blue_led      <= 1'b0;
         color_changed <= 1'b0;
         sensor_fault  <= 1'b0;
      end else begin
         color_changed <= 1'b0;
         if (cnt_valid)
            sensor_fault <= 1'b0;
         if (tmo_hit) begin
            sensor_fault  <= 1'b1;
            cand          <= 2'd0;
            run           <= '0;
            color_code    <= 2'd0;
            red_led       <= 1'b0;
            green_led     <= 1'b0;
            blue_led      <= 1'b0;
            color_changed <= (color_code != 2'd0);
         end else if (s2_v) begin
            cand <= cls;
            run  <= run_nxt;
            if ((run_nxt == RUN_MAX) && (cls != color_code)) begin
               color_code    <= cls;
               red_led       <= (cls == 2'd1);
               green_led     <= (cls == 2'd2);
               blue_led      <= (cls == 2'd3);
               color_changed <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_sm_color_classifier.sv
// Bench for sm_color_classifier: directed test-plan scenarios plus randomized sweeps,
// checked every cycle against a sweep-history reference model.
module tb_sm_color_classifier;

   localparam int W       = 21;
   localparam int TOL     = 200;
   localparam int CONFIRM = 4;
   localparam int TIMEOUT = 3000;

   logic         clk_50M = 1'b0;
   logic         reset;
   logic [W-1:0] red_cnt, blue_cnt, green_cnt, clear_cnt;
   logic         cnt_valid;
   logic [1:0]   color_code;
   logic         red_led, green_led, blue_led, color_changed, sensor_fault;

   int n_checks = 0;
   int n_fail   = 0;

   // reference signatures, channel order r, b, g, c
   int ref_tab [3][4] = '{'{1010, 1370, 1543, 480},
                          '{1510, 1400, 1390, 500},
                          '{1800,  970, 1630, 485}};

   int         m_code, m_fault, m_changed, m_idle;
   int         hist_q[$];
   logic [2:0] exp_q[$];

   always #10 clk_50M = ~clk_50M;

   sm_color_classifier #(.W(W), .TOL(TOL), .CONFIRM(CONFIRM), .TIMEOUT(TIMEOUT)) dut (
      .clk_50M      (clk_50M),
      .reset        (reset),
      .red_cnt      (red_cnt),
      .blue_cnt     (blue_cnt),
      .green_cnt    (green_cnt),
      .clear_cnt    (clear_cnt),
      .cnt_valid    (cnt_valid),
      .color_code   (color_code),
      .red_led      (red_led),
      .green_led    (green_led),
      .blue_led     (blue_led),
      .color_changed(color_changed),
      .sensor_fault (sensor_fault)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
      end
   endtask

   function automatic int class_of(input int r, input int b, input int g, input int c);
      int ch[4];
      int lo;
      bit ok;
      ch = '{r, b, g, c};
      if (r == 0 || b == 0 || g == 0 || c == 0) return 0;
      for (int k = 0; k < 3; k++) begin
         ok = 1'b1;
         for (int i = 0; i < 4; i++) begin
            lo = (ref_tab[k][i] > TOL) ? ref_tab[k][i] - TOL : 0;
            if (!(ch[i] > lo && ch[i] < ref_tab[k][i] + TOL)) ok = 1'b0;
         end
         if (ok) return k + 1;
      end
      return 0;
   endfunction

   task automatic model_reset();
      m_code    = 0;
      m_fault   = 0;
      m_changed = 0;
      m_idle    = 0;
      hist_q.delete();
      exp_q = '{3'b000, 3'b000};
   endtask

   // A sweep's class takes effect two edges after its capture edge; the stable code follows
   // the last CONFIRM classes when they all agree.
   task automatic model_edge(input bit v, input int cls);
      logic [2:0] out;
      bit         tmo;
      bit         same;
      tmo = 1'b0;
      if (v) begin
         m_idle  = 0;
         m_fault = 0;
      end else if (m_idle < TIMEOUT) begin
         m_idle++;
         if (m_idle == TIMEOUT) tmo = 1'b1;
      end
      out = exp_q.pop_front();
      exp_q.push_back({v, 2'(cls)});
      m_changed = 0;
      if (tmo) begin
         m_fault = 1;
         hist_q.delete();
         if (m_code != 0) m_changed = 1;
         m_code = 0;
      end else if (out[2]) begin
         hist_q.push_back(int'(out[1:0]));
         if (hist_q.size() > CONFIRM) void'(hist_q.pop_front());
         if (hist_q.size() == CONFIRM) begin
            same = 1'b1;
            foreach (hist_q[i]) if (hist_q[i] != hist_q[0]) same = 1'b0;
            if (same && hist_q[0] != m_code) begin
               m_code    = hist_q[0];
               m_changed = 1;
            end
         end
      end
   endtask

   task automatic check_outputs();
      check("code", 32'(color_code), 32'(m_code));
      check("leds", {29'd0, red_led, green_led, blue_led},
            {29'd0, m_code == 1, m_code == 2, m_code == 3});
      check("chg", 32'(color_changed), 32'(m_changed));
      check("fault", 32'(sensor_fault), 32'(m_fault));
   endtask

   task automatic step(input bit v, input int r, input int b, input int g, input int c);
      @(negedge clk_50M);
      cnt_valid = v;
      if (v) begin
         red_cnt   = W'(r);
         blue_cnt  = W'(b);
         green_cnt = W'(g);
         clear_cnt = W'(c);
      end else begin
         red_cnt   = W'($urandom);
         blue_cnt  = W'($urandom);
         green_cnt = W'($urandom);
         clear_cnt = W'($urandom);
      end
      @(posedge clk_50M);
      model_edge(v, class_of(r, b, g, c));
      #1;
      check_outputs();
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'b0, 0, 0, 0, 0);
   endtask

   task automatic sweeps(input int n, input int r, input int b, input int g, input int c,
                         input int gap);
      repeat (n) begin
         step(1'b1, r, b, g, c);
         idle(gap);
      end
   endtask

   task automatic do_reset();
      @(negedge clk_50M);
      reset     = 1'b1;
      cnt_valid = 1'b0;
      #1;
      model_reset();
      check_outputs();
      @(posedge clk_50M);
      #1;
      check_outputs();
      reset = 1'b0;
   endtask

   initial begin
      int tgt, reps;
      int v[4];
      reset     = 1'b1;
      cnt_valid = 1'b0;
      red_cnt   = '0;
      blue_cnt  = '0;
      green_cnt = '0;
      clear_cnt = '0;
      model_reset();
      #1;
      check_outputs();
      @(posedge clk_50M);
      #1;
      reset = 1'b0;

      sweeps(4, 1010, 1370, 1543, 480, 63);
      check("red_code", 32'(color_code), 32'd1);
      check("red_led", 32'(red_led), 32'd1);

      sweeps(3, 1800, 970, 1630, 485, 5);
      sweeps(1, 1010, 1370, 1543, 480, 5);
      check("hold_red", 32'(color_code), 32'd1);
      sweeps(4, 1800, 970, 1630, 485, 5);
      check("blue_code", 32'(color_code), 32'd3);
      check("blue_led", 32'(blue_led), 32'd1);

      sweeps(4, 810, 1370, 1543, 480, 3);
      check("bnd_810", 32'(color_code), 32'd0);
      sweeps(4, 811, 1370, 1543, 480, 3);
      check("bnd_811", 32'(color_code), 32'd1);
      sweeps(4, 1210, 1370, 1543, 480, 3);
      check("bnd_1210", 32'(color_code), 32'd0);
      sweeps(4, 1209, 1370, 1543, 480, 3);
      check("bnd_1209", 32'(color_code), 32'd1);
      sweeps(4, 1010, 1370, 1543, 0, 3);
      check("clear_zero", 32'(color_code), 32'd0);

      sweeps(4, 1510, 1400, 1390, 500, 0);
      idle(1);
      check("b2b_early", 32'(color_code), 32'd0);
      idle(1);
      check("b2b_green", 32'(color_code), 32'd2);

      idle(TIMEOUT + 5);
      check("tmo_fault", 32'(sensor_fault), 32'd1);
      check("tmo_code", 32'(color_code), 32'd0);
      sweeps(1, 1510, 1400, 1390, 500, 0);
      check("tmo_clear", 32'(sensor_fault), 32'd0);
      sweeps(3, 1510, 1400, 1390, 500, 3);
      check("tmo_restore", 32'(color_code), 32'd2);

      sweeps(2, 1010, 1370, 1543, 480, 3);
      do_reset();
      sweeps(2, 1010, 1370, 1543, 480, 3);
      check("rst_hold", 32'(color_code), 32'd0);
      sweeps(2, 1010, 1370, 1543, 480, 3);
      check("rst_red", 32'(color_code), 32'd1);

      for (int grp = 0; grp < 150; grp++) begin
         tgt  = int'($urandom_range(0, 3));
         reps = int'($urandom_range(1, 6));
         for (int k = 0; k < reps; k++) begin
            for (int i = 0; i < 4; i++) begin
               if (tgt == 0)
                  v[i] = int'($urandom_range(0, 2500));
               else
                  v[i] = ref_tab[tgt-1][i] + int'($urandom_range(0, 520)) - 260;
               if (v[i] < 0) v[i] = 0;
            end
            if ($urandom_range(0, 15) == 0) v[$urandom_range(0, 3)] = 0;
            step(1'b1, v[0], v[1], v[2], v[3]);
            idle(int'($urandom_range(0, 3)));
         end
         if (grp % 50 == 49) idle(TIMEOUT + int'($urandom_range(0, 20)));
      end
      idle(5);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
